product_accumulator: RTL

- Downstream stage of the synchronous 32x32 signed multiplier wrapper.
- Consumes its 64-bit signed products through a valid/ready handshake and sums a programmed number of them (dot-product / MAC reduction).
- Presents the wide sum with a sticky saturation flag to the next consumer.
- Decouples the multiplier's fixed issue cadence from a back-pressuring sink.

---
 rtl/product_accumulator.sv | 135 +++++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Sums a programmed number of 64-bit signed products received
//               over a valid/ready handshake into a saturating ACC_W-bit
//               accumulator. The result is held, together with a sticky
//               saturation flag, until the downstream sink accepts it.
// Ports       : clk, rst (async, active-high)
//               start, len              - begin an accumulation of len terms
//               in_valid, in_prod,      - product input handshake
//               in_ready
//               out_valid, out_ready,   - result output handshake
//               out_sum, out_count,
//               overflow
//               busy                    - state is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator #(
  parameter int ACC_W = 72,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [63:0]      in_prod,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [LEN_W-1:0] out_count,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_target;
  logic             r_ovf;

  logic [ACC_W:0]   w_prod_ext;
  logic [ACC_W:0]   w_sum_wide;
  logic             w_sat_hi;
  logic             w_sat_lo;
  logic [ACC_W-1:0] w_sum_sat;
  logic             w_xfer;
  logic [LEN_W-1:0] w_count_inc;

  // The add is carried out one bit wider than the accumulator so that the
  // true sign is always available; disagreement between the top two bits
  // means the result left the representable ACC_W-bit range.
  assign w_prod_ext = {{(ACC_W+1-64){in_prod[63]}}, in_prod};
  assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + w_prod_ext;
  assign w_sat_hi   = ~w_sum_wide[ACC_W] &  w_sum_wide[ACC_W-1];
  assign w_sat_lo   =  w_sum_wide[ACC_W] & ~w_sum_wide[ACC_W-1];

  always_comb begin
    w_sum_sat = w_sum_wide[ACC_W-1:0];
    if (w_sat_hi) begin
      w_sum_sat = c_acc_max;
    end else if (w_sat_lo) begin
      w_sum_sat = c_acc_min;
    end
  end

  assign w_xfer      = (r_state == ST_ACCUM) && in_valid;
  assign w_count_inc = r_count + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_count  <= '0;
      r_target <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_target <= len;
            r_acc    <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_state  <= (len != '0) ? ST_ACCUM : ST_HOLD;
          end
        end
        ST_ACCUM: begin
          if (w_xfer) begin
            r_acc   <= w_sum_sat;
            r_count <= w_count_inc;
            if (w_sat_hi || w_sat_lo) begin
              r_ovf <= 1'b1;
            end
            // Leave on the same edge that accepts the final term.
            if (w_count_inc == r_target) begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // out_valid is implied by this state, so out_ready alone decides.
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and status outputs are pure state decodes; the data outputs
  // come straight from registers, so no input reaches an output
  // combinationally.
  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_HOLD);
  assign busy      = (r_state != ST_IDLE);
  assign out_sum   = r_acc;
  assign out_count = r_count;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire
